// File: rtl/bb_pkg.sv
// Shared definitions for the Blackbone bus arbiter: FSM state encoding.
package bb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        HELD = ST_HELD
    } bb_state_e;

endpackage

// File: rtl/bb_arb_ctrl_if.sv
// Request/grant bundle between the Blackbone masters and the arbiter.
interface bb_arb_ctrl_if #(
    parameter int MASTERS = 4
);
    localparam int IW = $clog2(MASTERS);

    logic [MASTERS-1:0] m_en_i;
    logic               bus_hold_i;
    logic               bus_hold_ack_o;
    logic [MASTERS-1:0] grant_o;
    logic [IW-1:0]      grant_idx_o;
    logic               grant_vld_o;
    logic               err_o;
    logic [IW-1:0]      err_master_o;

    modport master (
        output m_en_i, bus_hold_i,
        input  bus_hold_ack_o, grant_o, grant_idx_o, grant_vld_o, err_o, err_master_o
    );

    modport slave (
        input  m_en_i, bus_hold_i,
        output bus_hold_ack_o, grant_o, grant_idx_o, grant_vld_o, err_o, err_master_o
    );

endinterface

// File: rtl/bb_rr_pick.sv
// Combinational round-robin search: first candidate after ptr, wrapping modulo N.
module bb_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0]  cand;
    logic [IW-1:0] pos;

    assign cand = req & ~excl;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!found && cand[pos]) begin
                found       = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bb_arb_ctrl.sv
// Round-robin Blackbone arbiter with quantum preemption, watchdog and bus parking.
//   state | meaning
//   IDLE  | no grant, ack=0
//   BUSY  | one master granted, ack=0
//   HELD  | bus parked for bus_hold_i, no grant, ack=1
module bb_arb_ctrl
    import bb_pkg::*;
#(
    parameter int MASTERS = 4,
    parameter int QUANTUM = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    bb_arb_ctrl_if.slave  bus
);

    localparam int IW = $clog2(MASTERS);
    localparam int QW = $clog2(QUANTUM + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [QW-1:0] Q_MAX = QW'(QUANTUM);
    localparam logic [WW-1:0] W_MAX = WW'(TIMEOUT);

    bb_state_e          state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [QW-1:0]      q_cnt_q, q_cnt_d;
    logic [WW-1:0]      w_cnt_q, w_cnt_d;
    logic [MASTERS-1:0] blocked_q, blocked_d;
    logic               err_q, err_d;
    logic [IW-1:0]      err_master_q, err_master_d;

    logic [MASTERS-1:0] elig;
    logic [MASTERS-1:0] pick_oh;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic               cur_en, wd_exp, q_exp;
    logic               go_next, new_grant;

    assign elig   = bus.m_en_i & ~blocked_q;
    assign cur_en = |(bus.m_en_i & grant_q);
    assign wd_exp = (state_q == BUSY) && cur_en && (w_cnt_q == W_MAX);
    assign q_exp  = (state_q == BUSY) && cur_en && (q_cnt_q == Q_MAX) && pick_found;

    // grant_q is zero outside BUSY, so excluding it only matters when rotating away
    bb_rr_pick #(.N(MASTERS), .IW(IW)) u_pick (
        .req    (elig),
        .ptr    (ptr_q),
        .excl   (grant_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        q_cnt_d      = q_cnt_q;
        w_cnt_d      = w_cnt_q;
        err_d        = 1'b0;
        err_master_d = err_master_q;
        blocked_d    = blocked_q & bus.m_en_i;
        go_next      = 1'b0;
        new_grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.bus_hold_i)  state_d = HELD;
                else if (pick_found) new_grant = 1'b1;
            end
            BUSY: begin
                if (wd_exp) begin
                    err_d        = 1'b1;
                    err_master_d = idx_q;
                    blocked_d    = blocked_d | grant_q;
                end
                if (!cur_en || wd_exp || q_exp) begin
                    go_next = 1'b1;
                end else begin
                    q_cnt_d = (q_cnt_q == Q_MAX) ? q_cnt_q : q_cnt_q + 1'b1;
                    w_cnt_d = (w_cnt_q == W_MAX) ? w_cnt_q : w_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!bus.bus_hold_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (go_next) begin
            if (bus.bus_hold_i) begin
                state_d = HELD;
                grant_d = '0;
            end else if (pick_found) begin
                new_grant = 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
            end
        end

        if (new_grant) begin
            state_d = BUSY;
            grant_d = pick_oh;
            idx_d   = pick_idx;
            ptr_d   = pick_idx;
            q_cnt_d = QW'(1);
            w_cnt_d = WW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            idx_q        <= '0;
            ptr_q        <= IW'(MASTERS - 1);
            q_cnt_q      <= '0;
            w_cnt_q      <= '0;
            blocked_q    <= '0;
            err_q        <= 1'b0;
            err_master_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            q_cnt_q      <= q_cnt_d;
            w_cnt_q      <= w_cnt_d;
            blocked_q    <= blocked_d;
            err_q        <= err_d;
            err_master_q <= err_master_d;
        end
    end

    assign bus.grant_o        = grant_q;
    assign bus.grant_idx_o    = idx_q;
    assign bus.grant_vld_o    = |grant_q;
    assign bus.bus_hold_ack_o = (state_q == HELD);
    assign bus.err_o          = err_q;
    assign bus.err_master_o   = err_master_q;

endmodule

// File: tb/tb_bb_arb_ctrl.sv
// Directed bench for bb_arb_ctrl with MASTERS=4, QUANTUM=4, TIMEOUT=16.
module tb_bb_arb_ctrl;

    localparam int M = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   miss_cnt = 0;

    always #5 clk = ~clk;

    bb_arb_ctrl_if #(.MASTERS(M)) bus ();

    bb_arb_ctrl #(.MASTERS(M), .QUANTUM(4), .TIMEOUT(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic ack);
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        chk({tag, ".vld"}, 32'(bus.grant_vld_o), 32'(|g));
        chk({tag, ".ack"}, 32'(bus.bus_hold_ack_o), 32'(ack));
    endtask

    initial begin
        bus.m_en_i     = '0;
        bus.bus_hold_i = 1'b0;
        rst_n          = 1'b0;
        tick();
        tick();
        chk_grant("rst", 4'b0000, 1'b0);
        chk("rst.idx", 32'(bus.grant_idx_o), 32'd0);
        chk("rst.err", 32'(bus.err_o), 32'd0);
        chk("rst.err_master", 32'(bus.err_master_o), 32'd0);
        rst_n = 1'b1;

        // first grant after reset goes to master 0; release hands straight to master 2
        bus.m_en_i = 4'b0101;
        tick();
        chk_grant("first", 4'b0001, 1'b0);
        chk("first.idx", 32'(bus.grant_idx_o), 32'd0);
        bus.m_en_i = 4'b0100;
        tick();
        chk_grant("handoff", 4'b0100, 1'b0);
        chk("handoff.idx", 32'(bus.grant_idx_o), 32'd2);
        bus.m_en_i = 4'b0000;
        tick();
        chk_grant("drop", 4'b0000, 1'b0);

        // two steady requesters alternate every QUANTUM cycles
        bus.m_en_i = 4'b0011;
        for (int t = 1; t <= 16; t++) begin
            tick();
            chk($sformatf("rr.t%0d", t), 32'(bus.grant_o),
                (((t - 1) / 4) % 2 == 0) ? 32'h1 : 32'h2);
        end
        bus.m_en_i = 4'b0000;
        tick();
        chk_grant("rr.end", 4'b0000, 1'b0);

        // lone requester: no quantum preemption, watchdog fires after 16 grant cycles
        bus.m_en_i = 4'b0001;
        for (int t = 1; t <= 20; t++) begin
            tick();
            chk($sformatf("wd.t%0d.grant", t), 32'(bus.grant_o), (t <= 16) ? 32'h1 : 32'h0);
            chk($sformatf("wd.t%0d.err", t), 32'(bus.err_o), (t == 17) ? 32'h1 : 32'h0);
            if (t >= 17) chk($sformatf("wd.t%0d.err_master", t), 32'(bus.err_master_o), 32'd0);
        end
        bus.m_en_i = 4'b0000;
        tick();
        chk_grant("wd.unblock", 4'b0000, 1'b0);
        bus.m_en_i = 4'b0001;
        tick();
        chk_grant("wd.regrant", 4'b0001, 1'b0);

        // hold while master 2 is granted waits for its release
        bus.m_en_i = 4'b0100;
        tick();
        chk_grant("hold.m2", 4'b0100, 1'b0);
        bus.bus_hold_i = 1'b1;
        tick();
        chk_grant("hold.wait1", 4'b0100, 1'b0);
        tick();
        chk_grant("hold.wait2", 4'b0100, 1'b0);
        bus.m_en_i = 4'b0000;
        tick();
        chk_grant("hold.ack", 4'b0000, 1'b1);
        bus.m_en_i = 4'b0011;
        tick();
        chk_grant("hold.ignore", 4'b0000, 1'b1);
        bus.bus_hold_i = 1'b0;
        tick();
        chk_grant("hold.release", 4'b0000, 1'b0);
        tick();
        chk_grant("hold.resume", 4'b0001, 1'b0);
        bus.m_en_i = 4'b0000;
        tick();
        chk_grant("hold.idle", 4'b0000, 1'b0);

        // hold beats a simultaneous request from IDLE
        bus.bus_hold_i = 1'b1;
        bus.m_en_i     = 4'b0010;
        tick();
        chk_grant("idlehold", 4'b0000, 1'b1);
        bus.bus_hold_i = 1'b0;
        bus.m_en_i     = 4'b0000;
        tick();
        chk_grant("idlehold.rel", 4'b0000, 1'b0);

        // quantum expiry with hold pending parks the bus instead of rotating
        bus.m_en_i = 4'b0011;
        tick();
        chk_grant("qhold.t1", 4'b0010, 1'b0);
        bus.bus_hold_i = 1'b1;
        tick();
        tick();
        tick();
        chk_grant("qhold.t4", 4'b0010, 1'b0);
        tick();
        chk_grant("qhold.park", 4'b0000, 1'b1);
        bus.bus_hold_i = 1'b0;
        bus.m_en_i     = 4'b0000;
        tick();
        chk_grant("qhold.rel", 4'b0000, 1'b0);

        // reset mid-grant, then master 3 runs into the watchdog
        bus.m_en_i = 4'b0001;
        tick();
        tick();
        tick();
        chk_grant("rstmid.busy", 4'b0001, 1'b0);
        rst_n      = 1'b0;
        bus.m_en_i = 4'b1000;
        tick();
        chk_grant("rstmid", 4'b0000, 1'b0);
        chk("rstmid.err", 32'(bus.err_o), 32'd0);
        rst_n = 1'b1;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk($sformatf("m3.t%0d.grant", t), 32'(bus.grant_o), (t <= 16) ? 32'h8 : 32'h0);
        end
        chk("m3.idx", 32'(bus.grant_idx_o), 32'd3);
        chk("m3.err", 32'(bus.err_o), 32'd1);
        chk("m3.err_master", 32'(bus.err_master_o), 32'd3);
        bus.m_en_i = 4'b0000;
        tick();
        chk("m3.err_off", 32'(bus.err_o), 32'd0);
        chk("m3.err_master_hold", 32'(bus.err_master_o), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
